// File: rtl/sseg_scanner.sv
// Recovers the hex digits shown on a multiplexed, active-low seven-segment display
// by sampling the segment/anode pins and capturing each digit once it has been stable.
module sseg_scanner #(
   parameter int NDIGITS       = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [6:0]             sseg,
   input  logic [NDIGITS-1:0]     anode,
   input  logic                   clear,
   output logic [4*NDIGITS-1:0]   hexa,
   output logic [NDIGITS-1:0]     valid,
   output logic [NDIGITS-1:0]     error,
   output logic                   update,
   output logic                   scan_state
);

   typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

   localparam int PW = NDIGITS + 7;
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   s1, s2, prev;
   logic [NDIGITS-1:0] s2_anode;
   logic [6:0]      s2_sseg;
   logic            changed;
   logic            one_digit;
   logic [3:0]      nib;
   logic            legal;

   assign s2_anode   = s2[PW-1:7];
   assign s2_sseg    = s2[6:0];
   assign changed    = (s2 != prev);
   assign one_digit  = $onehot(~s2_anode);
   assign scan_state = state;

   // Only the sixteen canonical hex glyphs are legal; everything else is an error.
   always_comb begin
      nib   = 4'h0;
      legal = 1'b1;
      case (s2_sseg)
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1     <= '1;
         s2     <= '1;
         prev   <= '1;
         state  <= TRACK;
         cnt    <= '0;
         hexa   <= '0;
         valid  <= '0;
         error  <= '0;
         update <= 1'b0;
      end else begin
         s1     <= {anode, sseg};
         s2     <= s1;
         prev   <= s2;
         update <= 1'b0;
         if (clear) begin
            valid <= '0;
            error <= '0;
         end
         // Capture writes come after the clear so the captured digit wins.
         case (state)
            TRACK: begin
               if (changed) begin
                  cnt <= '0;
               end else if (cnt == LAST) begin
                  state <= HOLD;
                  if (one_digit) begin
                     update <= 1'b1;
                     for (int i = 0; i < NDIGITS; i++) begin
                        if (!s2_anode[i]) begin
                           if (legal) begin
                              hexa[4*i +: 4] <= nib;
                              valid[i]       <= 1'b1;
                              error[i]       <= 1'b0;
                           end else begin
                              valid[i]       <= 1'b0;
                              error[i]       <= 1'b1;
                           end
                        end
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               if (changed) begin
                  cnt   <= '0;
                  state <= TRACK;
               end
            end
            default: state <= TRACK;
         endcase
      end
   end

endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner with NDIGITS=4, STABLE_CYCLES=4: a vector table
// plus hand-timed sequences for latency, glitch filtering, clear overlap and reset.
module tb_sseg_scanner;

   logic        clock;
   logic        reset;
   logic [6:0]  sseg;
   logic [3:0]  anode;
   logic        clear;
   logic [15:0] hexa;
   logic [3:0]  valid;
   logic [3:0]  error;
   logic        update;
   logic        scan_state;

   int checks;
   int errors;
   int pulses;
   logic last_upd;

   typedef struct {
      logic [3:0]  anode;
      logic [6:0]  sseg;
      logic        clear;
      logic [15:0] hexa;
      logic [3:0]  valid;
      logic [3:0]  error;
      int          pulses;
   } vec_t;

   vec_t vecs[$];

   sseg_scanner #(.NDIGITS(4), .STABLE_CYCLES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .sseg       (sseg),
      .anode      (anode),
      .clear      (clear),
      .hexa       (hexa),
      .valid      (valid),
      .error      (error),
      .update     (update),
      .scan_state (scan_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Advance one edge, sample just after it, and watch for back-to-back pulses.
   task automatic tick();
      @(posedge clock);
      #1;
      if (update === 1'b1) begin
         pulses++;
         check("update_not_back_to_back", {31'd0, last_upd}, 32'd0);
      end
      last_upd = update;
   endtask

   initial begin
      int p0;
      checks   = 0;
      errors   = 0;
      pulses   = 0;
      last_upd = 1'b0;
      reset    = 1'b1;
      anode    = 4'b1111;
      sseg     = 7'h7F;
      clear    = 1'b0;

      vecs.push_back('{4'b0111, 7'h0E, 1'b0, 16'hF002, 4'b1001, 4'b0000, 1});
      vecs.push_back('{4'b1011, 7'h21, 1'b0, 16'hFD02, 4'b1101, 4'b0000, 1});
      vecs.push_back('{4'b1101, 7'h19, 1'b0, 16'hFD42, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b1101, 7'h7F, 1'b0, 16'hFD42, 4'b1101, 4'b0010, 1});
      vecs.push_back('{4'b1100, 7'h40, 1'b0, 16'hFD42, 4'b1101, 4'b0010, 0});
      vecs.push_back('{4'b1111, 7'h40, 1'b0, 16'hFD42, 4'b1101, 4'b0010, 0});
      vecs.push_back('{4'b1110, 7'h46, 1'b0, 16'hFD4C, 4'b1101, 4'b0010, 1});
      vecs.push_back('{4'b1110, 7'h46, 1'b1, 16'hFD4C, 4'b0000, 4'b0000, 0});
      vecs.push_back('{4'b1101, 7'h03, 1'b0, 16'hFDBC, 4'b0010, 4'b0000, 1});
      vecs.push_back('{4'b1110, 7'h7F, 1'b0, 16'hFDBC, 4'b0010, 4'b0001, 1});
      vecs.push_back('{4'b0111, 7'h06, 1'b0, 16'hEDBC, 4'b1010, 4'b0001, 1});
      vecs.push_back('{4'b1011, 7'h12, 1'b0, 16'hE5BC, 4'b1110, 4'b0001, 1});
      vecs.push_back('{4'b1110, 7'h10, 1'b0, 16'hE5B9, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b1110, 7'h08, 1'b0, 16'hE5BA, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b1101, 7'h78, 1'b0, 16'hE57A, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b1011, 7'h02, 1'b0, 16'hE67A, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b0111, 7'h00, 1'b0, 16'h867A, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b0111, 7'h40, 1'b0, 16'h067A, 4'b1111, 4'b0000, 1});
      vecs.push_back('{4'b1110, 7'h5A, 1'b0, 16'h067A, 4'b1110, 4'b0001, 1});

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("reset_hexa",   {16'd0, hexa},  32'h0);
      check("reset_valid",  {28'd0, valid}, 32'h0);
      check("reset_error",  {28'd0, error}, 32'h0);
      check("reset_update", {31'd0, update}, 32'h0);
      check("reset_state",  {31'd0, scan_state}, 32'h0);

      // First capture lands exactly on edge 7 after release
      reset = 1'b0;
      anode = 4'b1110;
      sseg  = 7'h24;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check($sformatf("latency_quiet_e%0d", e), {31'd0, update}, 32'h0);
      end
      tick();
      check("latency_update_e7", {31'd0, update}, 32'h1);
      check("latency_hexa",      {16'd0, hexa},  32'h0002);
      check("latency_valid",     {28'd0, valid}, 32'h1);
      check("latency_error",     {28'd0, error}, 32'h0);
      check("latency_hold_state", {31'd0, scan_state}, 32'h1);
      p0 = pulses;
      repeat (10) tick();
      check("held_no_repulse", pulses - p0, 32'd0);

      // Table of held patterns
      foreach (vecs[k]) begin
         anode = vecs[k].anode;
         sseg  = vecs[k].sseg;
         clear = vecs[k].clear;
         p0 = pulses;
         repeat (10) tick();
         clear = 1'b0;
         check($sformatf("vec%0d_hexa", k),   {16'd0, hexa},  {16'd0, vecs[k].hexa});
         check($sformatf("vec%0d_valid", k),  {28'd0, valid}, {28'd0, vecs[k].valid});
         check($sformatf("vec%0d_error", k),  {28'd0, error}, {28'd0, vecs[k].error});
         check($sformatf("vec%0d_pulses", k), pulses - p0,    vecs[k].pulses);
      end

      // clear on the very cycle a digit-0 capture completes
      anode = 4'b1110;
      sseg  = 7'h30;
      repeat (6) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clrcap_update", {31'd0, update}, 32'h1);
      check("clrcap_valid",  {28'd0, valid},  32'b0001);
      check("clrcap_error",  {28'd0, error},  32'b0000);
      check("clrcap_hexa",   {16'd0, hexa},   32'h0673);
      repeat (4) tick();

      // Glitchy digit: toggles every two cycles, then settles
      p0 = pulses;
      for (int k = 0; k < 7; k++) begin
         sseg = (k % 2 == 0) ? 7'h40 : 7'h79;
         tick();
         tick();
      end
      check("glitch_no_capture", pulses - p0, 32'd0);
      sseg = 7'h79;
      p0 = pulses;
      repeat (6) tick();
      check("settle_quiet", pulses - p0, 32'd0);
      tick();
      check("settle_update_e7", {31'd0, update}, 32'h1);
      check("settle_hexa",      {16'd0, hexa},   32'h0671);
      check("settle_valid",     {28'd0, valid},  32'b0001);
      repeat (4) tick();

      // Reset at count 2 aborts the pending capture
      anode = 4'b1101;
      sseg  = 7'h24;
      p0 = pulses;
      repeat (5) tick();
      reset = 1'b1;
      #1;
      check("midreset_hexa",   {16'd0, hexa},  32'h0);
      check("midreset_valid",  {28'd0, valid}, 32'h0);
      check("midreset_error",  {28'd0, error}, 32'h0);
      check("midreset_update", {31'd0, update}, 32'h0);
      tick();
      reset = 1'b0;
      check("midreset_no_pulse", pulses - p0, 32'd0);
      repeat (6) tick();
      check("postreset_quiet", pulses - p0, 32'd0);
      tick();
      check("postreset_update_e7", {31'd0, update}, 32'h1);
      check("postreset_hexa",      {16'd0, hexa},   32'h0020);
      check("postreset_valid",     {28'd0, valid},  32'b0010);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
